id_exe_pipe_stage: RTL and testbench
====================================

// Module: id_exe_pipe_stage
// PURPOSE
//  Parametrised ID->EXE pipeline stage with a valid/ready handshake, an optional
//  2-entry skid buffer, a synchronous flush and a saturating stall counter.
//  Sits between the decode/regfile stage and the ALU.
//  It carries operands (a, b, imm), the destination register and the ALU/memory
//  control bundle. A squashed or empty slot presents all-zero control (NOP).
// PARAMETERS
//  DW     32  operand width (a, b, imm)
//  RNW    5   destination register index width
//  ALUCW  3   ALU control width
//  CTRLW  6   control flag bundle {wreg,m2reg,wmem,aluimm,shift,wz}, bit 5 = wreg
//  SKID   1   1 = 2-entry skid buffer (registered in_ready); 0 = single register
//  CNTW   16  stall counter width
// PORTS
//  clk        in   1      clock, rising edge
//  clrn       in   1      asynchronous active-low reset
//  in_valid   in   1      ID slot holds a valid instruction
//  in_ready   out  1      stage can accept this cycle
//  id_a       in   DW     operand A
//  id_b       in   DW     operand B
//  id_imm     in   DW     extended immediate
//  id_rn      in   RNW    destination register
//  id_aluc    in   ALUCW  ALU control
//  id_ctrl    in   CTRLW  control flags
//  flush      in   1      squash all held and incoming entries (branch/jump)
//  out_valid  out  1      EXE slot holds a valid instruction
//  out_ready  in   1      EXE consumes the slot this cycle
//  exe_a      out  DW     registered operand A
//  exe_b      out  DW     registered operand B
//  exe_imm    out  DW     registered immediate
//  exe_rn     out  RNW    registered destination
//  exe_aluc   out  ALUCW  registered ALU control
//  exe_ctrl   out  CTRLW  registered flags; forced 0 whenever out_valid=0
//  stall_cnt  out  CNTW   cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  - Reset (clrn=0, asynchronous): out_valid=0; skid empty; exe_* = 0; stall_cnt=0.
//    in_ready=1 while in reset and on the first edge after release.
//  - Accept: in_valid&in_ready. Consume: out_valid&out_ready. All updates on posedge clk.
//  - Latency: 1 cycle from accept to out_valid when the output register is empty or consumed.
//  - SKID=0: in_ready = out_ready | ~out_valid (combinational).
//    Output register loads on accept; out_valid clears on a consume without an accept.
//  - SKID=1: in_ready = ~skid_full (registered; no combinational path from out_ready).
//    States EMPTY / ONE (output reg full) / TWO (output reg + skid full).
//    EMPTY --accept--> ONE.
//    ONE: accept & consume -> ONE, new data in the output register.
//    ONE: accept & ~consume -> TWO, data captured in skid.
//    ONE: ~accept & consume -> EMPTY.
//    TWO: consume -> ONE, skid moves to the output register. in_ready=0 in TWO.
//  - Order is preserved: the skid entry always leaves before any later input.
//  - flush (priority over all): next state EMPTY, out_valid=0, skid cleared.
//    An input accepted in the flush cycle is discarded.
//    A consume in the flush cycle still counts as delivered downstream.
//  - Bubble rule: exe_ctrl=0 when out_valid=0, so wreg/wmem never leak from a bubble.
//    exe_a/b/imm/rn/aluc hold their last value; they carry no meaning when invalid.
//  - stall_cnt += 1 on each cycle with out_valid & ~out_ready.
//    It holds at 2^CNTW-1 and never wraps. Only reset clears it; flush does not.
//  - Reset mid-transfer: all entries lost, no partial output. Widths pass through unchanged.
// TESTING
//  1 Reset: drive clrn=0 mid-stream -> out_valid=0, exe_ctrl=0, stall_cnt=0 immediately (async).
//  2 Streaming: in_valid=1, out_ready=1 for 8 cycles with id_a=1..8 ->
//    exe_a=1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1.
//  3 Back-pressure, SKID=1: drop out_ready for 3 cycles while sending A=0x11, 0x22, 0x33
//    -> in_ready=0 after 0x22 is captured, 0x33 held at the source, stall_cnt=3.
//    Releasing out_ready delivers 0x11, 0x22, 0x33 in order with no loss or duplication.
//  4 Flush while in TWO with in_valid=1 -> next cycle out_valid=0, exe_ctrl=6'b0, in_ready=1,
//    and none of the three entries ever appears.
//  5 Saturation with CNTW=4: hold out_ready=0 for 20 cycles -> stall_cnt stops at 15.
//  6 SKID=0: same stimulus as 3 -> in_ready follows out_ready in the same cycle;
//    output order and values are identical to the SKID=1 run.

Source files
------------

// File: rtl/id_exe_pipe_stage.sv
// rtl/id_exe_pipe_stage.sv - ID->EXE pipeline register with valid/ready, optional skid entry, flush and stall counter
module id_exe_pipe_stage #(
    parameter int DW    = 32,
    parameter int RNW   = 5,
    parameter int ALUCW = 3,
    parameter int CTRLW = 6,
    parameter int SKID  = 1,
    parameter int CNTW  = 16
) (
    input  logic             clk_i,
    input  logic             clrn_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    id_a_i,
    input  logic [DW-1:0]    id_b_i,
    input  logic [DW-1:0]    id_imm_i,
    input  logic [RNW-1:0]   id_rn_i,
    input  logic [ALUCW-1:0] id_aluc_i,
    input  logic [CTRLW-1:0] id_ctrl_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    exe_a_o,
    output logic [DW-1:0]    exe_b_o,
    output logic [DW-1:0]    exe_imm_o,
    output logic [RNW-1:0]   exe_rn_o,
    output logic [ALUCW-1:0] exe_aluc_o,
    output logic [CTRLW-1:0] exe_ctrl_o,
    output logic [CNTW-1:0]  stall_cnt_o
);

    localparam int  PW       = 3 * DW + RNW + ALUCW + CTRLW;
    localparam bit  USE_SKID = (SKID != 0);

    logic [PW-1:0]    in_pl;
    logic [PW-1:0]    out_pl_q, out_pl_d;
    logic [PW-1:0]    skid_pl_q, skid_pl_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNTW-1:0]  stall_q, stall_d;
    logic [CTRLW-1:0] ctrl_raw;
    logic             accept;
    logic             consume;

    assign in_pl   = {id_a_i, id_b_i, id_imm_i, id_rn_i, id_aluc_i, id_ctrl_i};
    assign accept  = in_valid_i & in_ready_o;
    assign consume = out_valid_q & out_ready_i;

    // With a skid entry, ready is a flop output so out_ready never reaches in_ready combinationally
    generate
        if (USE_SKID) begin : g_ready_skid
            assign in_ready_o = ~skid_valid_q;
        end else begin : g_ready_pass
            assign in_ready_o = out_ready_i | ~out_valid_q;
        end
    endgenerate

    // Next-state: flush wins; the skid entry always drains before any newer input is taken
    always_comb begin
        out_pl_d     = out_pl_q;
        skid_pl_d    = skid_pl_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
                out_pl_d     = skid_pl_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_pl_d    = in_pl;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept && USE_SKID) begin
            skid_pl_d    = in_pl;
            skid_valid_d = 1'b1;
        end
    end

    // Stall counter saturates at all-ones; flush leaves it untouched
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready_i && (stall_q != {CNTW{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // State registers; reset drops every held entry
    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            out_pl_q     <= '0;
            skid_pl_q    <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            out_pl_q     <= out_pl_d;
            skid_pl_q    <= skid_pl_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_q      <= stall_d;
        end
    end

    assign {exe_a_o, exe_b_o, exe_imm_o, exe_rn_o, exe_aluc_o, ctrl_raw} = out_pl_q;
    // A bubble must never carry wreg/wmem into EXE
    assign exe_ctrl_o  = out_valid_q ? ctrl_raw : '0;
    assign out_valid_o = out_valid_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_id_exe_pipe_stage.sv
// tb/tb_id_exe_pipe_stage.sv - scoreboard bench running a SKID=1 and a SKID=0 stage side by side
module tb_id_exe_pipe_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rn;
        logic [2:0]  aluc;
        logic [5:0]  ctrl;
    } item_t;

    logic  clk = 1'b0;
    logic  clrn;
    logic  flush;
    logic  out_ready;
    logic  in_valid0, in_valid1;
    logic  in_ready0, in_ready1;
    logic  out_valid0, out_valid1;
    item_t din0, din1;
    item_t dout0, dout1;
    logic [15:0] stall0;
    logic [3:0]  stall1;

    item_t src0[$];
    item_t src1[$];
    item_t exp0[$];
    item_t exp1[$];

    int n_cmp = 0;
    int n_err = 0;
    int del0  = 0;
    int del1  = 0;
    logic acc0, acc1;

    always #5 clk = ~clk;

    id_exe_pipe_stage #(.SKID(0), .CNTW(16)) dut0 (
        .clk_i(clk), .clrn_i(clrn), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .id_a_i(din0.a), .id_b_i(din0.b), .id_imm_i(din0.imm), .id_rn_i(din0.rn),
        .id_aluc_i(din0.aluc), .id_ctrl_i(din0.ctrl), .flush_i(flush),
        .out_valid_o(out_valid0), .out_ready_i(out_ready),
        .exe_a_o(dout0.a), .exe_b_o(dout0.b), .exe_imm_o(dout0.imm), .exe_rn_o(dout0.rn),
        .exe_aluc_o(dout0.aluc), .exe_ctrl_o(dout0.ctrl), .stall_cnt_o(stall0)
    );

    id_exe_pipe_stage #(.SKID(1), .CNTW(4)) dut1 (
        .clk_i(clk), .clrn_i(clrn), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .id_a_i(din1.a), .id_b_i(din1.b), .id_imm_i(din1.imm), .id_rn_i(din1.rn),
        .id_aluc_i(din1.aluc), .id_ctrl_i(din1.ctrl), .flush_i(flush),
        .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .exe_a_o(dout1.a), .exe_b_o(dout1.b), .exe_imm_o(dout1.imm), .exe_rn_o(dout1.rn),
        .exe_aluc_o(dout1.aluc), .exe_ctrl_o(dout1.ctrl), .stall_cnt_o(stall1)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic item_t mk(input logic [31:0] v);
        item_t it;
        it.a    = v;
        it.b    = ~v;
        it.imm  = v << 4;
        it.rn   = v[4:0];
        it.aluc = v[2:0];
        it.ctrl = {1'b1, v[4:0]};
        return it;
    endfunction

    task automatic push_item(input logic [31:0] v);
        src0.push_back(mk(v));
        src1.push_back(mk(v));
        exp0.push_back(mk(v));
        exp1.push_back(mk(v));
    endtask

    task automatic clear_all();
        src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    // One clock: note accepts before the edge, then advance each source after it
    task automatic step();
        @(negedge clk);
        acc0 = in_valid0 & in_ready0;
        acc1 = in_valid1 & in_ready1;
        @(posedge clk);
        #1;
        if (flush) begin
            clear_all();
            flush = 1'b0;
        end else begin
            if (acc0 && src0.size() > 0) void'(src0.pop_front());
            if (acc1 && src1.size() > 0) void'(src1.pop_front());
        end
        if (src0.size() > 0) begin in_valid0 = 1'b1; din0 = src0[0]; end else in_valid0 = 1'b0;
        if (src1.size() > 0) begin in_valid1 = 1'b1; din1 = src1[0]; end else in_valid1 = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: every delivered slot must match the oldest outstanding item; bubbles carry no control
    always @(negedge clk) begin
        if (out_valid0 && out_ready) begin
            if (exp0.size() == 0) check("s0_unexpected_out", dout0, 128'h0);
            else check("s0_out_item", dout0, exp0.pop_front());
            del0++;
        end
        if (!out_valid0) check("s0_bubble_ctrl", dout0.ctrl, 6'h0);
        if (out_valid1 && out_ready) begin
            if (exp1.size() == 0) check("s1_unexpected_out", dout1, 128'h0);
            else check("s1_out_item", dout1, exp1.pop_front());
            del1++;
        end
        if (!out_valid1) check("s1_bubble_ctrl", dout1.ctrl, 6'h0);
    end

    initial begin
        clrn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        din0 = '0; din1 = '0; acc0 = 1'b0; acc1 = 1'b0;
        #3;
        check("rst_out_valid0", out_valid0, 0);
        check("rst_out_valid1", out_valid1, 0);
        check("rst_in_ready0", in_ready0, 1);
        check("rst_in_ready1", in_ready1, 1);
        check("rst_exe_a1", dout1.a, 0);
        check("rst_stall1", stall1, 0);
        steps(2);
        clrn = 1'b1;
        check("post_rst_in_ready1", in_ready1, 1);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int v = 1; v <= 8; v++) push_item(v);
        for (int i = 0; i < 9; i++) begin
            step();
            check("stream_in_ready0", in_ready0, 1);
            check("stream_in_ready1", in_ready1, 1);
        end
        check("stream_del0_9", del0, 7);
        check("stream_del1_9", del1, 7);
        step();
        check("stream_del0_10", del0, 8);
        check("stream_del1_10", del1, 8);
        steps(2);

        // Back-pressure: three items while out_ready is low
        out_ready = 1'b0;
        push_item(32'h11); push_item(32'h22); push_item(32'h33);
        steps(3);
        check("bp_in_ready1_two", in_ready1, 0);
        check("bp_in_ready0_full", in_ready0, 0);
        steps(2);
        check("bp_stall1", stall1, 3);
        check("bp_stall0", stall0, 3);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready0_comb", in_ready0, 1);
        check("bp_in_ready1_reg", in_ready1, 0);
        steps(5);
        check("bp_del0", del0, 11);
        check("bp_del1", del1, 11);
        check("bp_exp0_empty", exp0.size(), 0);
        check("bp_exp1_empty", exp1.size(), 0);
        check("bp_stall1_hold", stall1, 3);

        // Flush while the skid stage holds two entries and a third waits
        out_ready = 1'b0;
        push_item(32'hA1); push_item(32'hA2); push_item(32'hA3);
        steps(3);
        check("fl_in_ready1_two", in_ready1, 0);
        flush = 1'b1;
        step();
        check("fl_out_valid0", out_valid0, 0);
        check("fl_out_valid1", out_valid1, 0);
        check("fl_exe_ctrl1", dout1.ctrl, 0);
        check("fl_in_ready0", in_ready0, 1);
        check("fl_in_ready1", in_ready1, 1);
        check("fl_stall0_kept", stall0, 5);
        check("fl_stall1_kept", stall1, 5);
        out_ready = 1'b1;
        push_item(32'h55);
        steps(4);
        check("fl_del0", del0, 12);
        check("fl_del1", del1, 12);

        // Saturation: 20 stalled cycles on top of 5
        out_ready = 1'b0;
        push_item(32'h66);
        steps(22);
        check("sat_stall1", stall1, 15);
        check("sat_stall0", stall0, 25);
        out_ready = 1'b1;
        steps(3);
        check("sat_del1", del1, 13);
        check("sat_stall1_hold", stall1, 15);

        // Asynchronous reset in the middle of a transfer
        push_item(32'h71); push_item(32'h72); push_item(32'h73);
        steps(2);
        check("ar_pre_valid1", out_valid1, 1);
        clrn = 1'b0;
        #1;
        check("ar_out_valid0", out_valid0, 0);
        check("ar_out_valid1", out_valid1, 0);
        check("ar_exe_ctrl1", dout1.ctrl, 0);
        check("ar_stall0", stall0, 0);
        check("ar_stall1", stall1, 0);
        check("ar_in_ready0", in_ready0, 1);
        check("ar_in_ready1", in_ready1, 1);
        clear_all();
        steps(2);
        clrn = 1'b1;
        step();
        check("ar_rel_in_ready1", in_ready1, 1);
        steps(3);
        check("ar_del0", del0, 13);
        check("ar_del1", del1, 13);
        check("ar_idle_valid1", out_valid1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
